hazard_pipe_ctrl: RTL and testbench

- Consumer side of the hazard-detection interface in the 5-stage pipelined RISC-V core.
- Takes the load-use stall request, the forwarding selects and the EX-stage branch-taken signal. Drives the PC, IF/DE and DE/EX pipeline-register controls.
- Applies the forwarding selects to produce the ALU operands, and registers forwarded store data into EX/MEM.
- Keeps saturating stall and flush event counters for performance debug.

---
 rtl/hazard_pipe_ctrl.sv | 135 +++++++++++++
 tb/tb_hazard_pipe_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_pipe_ctrl.sv
// Pipeline hazard control: PC / IF-DE / DE-EX enables, ALU operand forwarding, store-data register, event counters.
// Latency: control outputs and ALU operands are combinational; store data appears one edge after its select.
// Backpressure: a load-use request freezes PC and IF/DE for one cycle; a taken branch squashes IF/DE and DE/EX.
module hazard_pipe_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             lw_stall,
    input  logic             br_taken,
    input  logic [1:0]       forwardA,
    input  logic [1:0]       forwardB,
    input  logic [1:0]       forwardtoStore,
    input  logic [XLEN-1:0]  de_ex_rs1_data,
    input  logic [XLEN-1:0]  de_ex_rs2_data,
    input  logic [XLEN-1:0]  ex_mem_alu_result,
    input  logic [XLEN-1:0]  mem_wb_alu_result,
    input  logic [XLEN-1:0]  mem_wb_load_data,
    input  logic [XLEN-1:0]  mem_wb_wd,
    output logic             pc_we,
    output logic             if_de_we,
    output logic             if_de_flush,
    output logic             de_ex_bubble,
    output logic [XLEN-1:0]  fwd_opA,
    output logic [XLEN-1:0]  fwd_opB,
    output logic [XLEN-1:0]  ex_mem_store_data,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   store_q, store_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    // A branch is honoured unless EX already holds a flush bubble; a stall only from RUN and only if no branch.
    logic br_evt;
    logic stall_evt;
    assign br_evt    = !RST && br_taken && (state_q != FLUSH);
    assign stall_evt = !RST && lw_stall && !br_taken && (state_q == RUN);

    // State, store-data and counter registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= RUN;
            store_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            store_q     <= store_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state: STALL and FLUSH each last exactly one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (br_taken)      state_d = FLUSH;
                else if (lw_stall) state_d = STALL;
                else               state_d = RUN;
            end
            STALL: begin
                if (br_taken) state_d = FLUSH;
                else          state_d = RUN;
            end
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Control outputs: RUN values by default, overridden by the event accepted this cycle
    always_comb begin
        pc_we        = 1'b1;
        if_de_we     = 1'b1;
        if_de_flush  = 1'b0;
        de_ex_bubble = 1'b0;
        if (br_evt) begin
            if_de_flush  = 1'b1;
            de_ex_bubble = 1'b1;
        end else if (stall_evt) begin
            pc_we        = 1'b0;
            if_de_we     = 1'b0;
            de_ex_bubble = 1'b1;
        end
    end

    // Saturating event counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_evt && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (br_evt && (flush_cnt_q != {CNT_W{1'b1}}))    flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    // ALU operand forwarding muxes
    always_comb begin
        case (forwardA)
            2'b01:   fwd_opA = ex_mem_alu_result;
            2'b10:   fwd_opA = mem_wb_alu_result;
            2'b11:   fwd_opA = mem_wb_load_data;
            default: fwd_opA = de_ex_rs1_data;
        endcase
        case (forwardB)
            2'b01:   fwd_opB = ex_mem_alu_result;
            2'b10:   fwd_opB = mem_wb_alu_result;
            2'b11:   fwd_opB = mem_wb_load_data;
            default: fwd_opB = de_ex_rs2_data;
        endcase
    end

    // Store-data select; the unused encoding falls back to the register value
    always_comb begin
        case (forwardtoStore)
            2'b01:   store_d = ex_mem_alu_result;
            2'b10:   store_d = mem_wb_wd;
            default: store_d = de_ex_rs2_data;
        endcase
    end

    assign ex_mem_store_data = store_q;
    assign stall_cnt         = stall_cnt_q;
    assign flush_cnt         = flush_cnt_q;

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
module tb_hazard_pipe_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        lw_stall, br_taken;
    logic [1:0]  forwardA, forwardB, forwardtoStore;
    logic [31:0] rs1, rs2, exm, mwa, mwl, mwd;

    logic        pc_we, if_de_we, if_de_flush, de_ex_bubble;
    logic [31:0] fwd_opA, fwd_opB, store_data;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_we, s_if_de_we, s_if_de_flush, s_de_ex_bubble;
    logic [31:0] s_fwd_opA, s_fwd_opB, s_store_data;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t exp_q[$];

    always #5 CLK = ~CLK;

    hazard_pipe_ctrl #(.XLEN(32), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .lw_stall(lw_stall), .br_taken(br_taken),
        .forwardA(forwardA), .forwardB(forwardB), .forwardtoStore(forwardtoStore),
        .de_ex_rs1_data(rs1), .de_ex_rs2_data(rs2), .ex_mem_alu_result(exm),
        .mem_wb_alu_result(mwa), .mem_wb_load_data(mwl), .mem_wb_wd(mwd),
        .pc_we(pc_we), .if_de_we(if_de_we), .if_de_flush(if_de_flush), .de_ex_bubble(de_ex_bubble),
        .fwd_opA(fwd_opA), .fwd_opB(fwd_opB), .ex_mem_store_data(store_data),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, used for saturation
    hazard_pipe_ctrl #(.XLEN(32), .CNT_W(2)) dut_sat (
        .CLK(CLK), .RST(RST), .lw_stall(lw_stall), .br_taken(br_taken),
        .forwardA(forwardA), .forwardB(forwardB), .forwardtoStore(forwardtoStore),
        .de_ex_rs1_data(rs1), .de_ex_rs2_data(rs2), .ex_mem_alu_result(exm),
        .mem_wb_alu_result(mwa), .mem_wb_load_data(mwl), .mem_wb_wd(mwd),
        .pc_we(s_pc_we), .if_de_we(s_if_de_we), .if_de_flush(s_if_de_flush), .de_ex_bubble(s_de_ex_bubble),
        .fwd_opA(s_fwd_opA), .fwd_opB(s_fwd_opB), .ex_mem_store_data(s_store_data),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic push_exp(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    // Pop the oldest expectation and compare it with what the DUT shows now
    task automatic check_next(input logic [31:0] obs);
        exp_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                fails++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // {pc_we, if_de_we, if_de_flush, de_ex_bubble}
    function automatic logic [31:0] ctrl();
        return {28'd0, pc_we, if_de_we, if_de_flush, de_ex_bubble};
    endfunction

    task automatic chk_ctrl(input string tag, input logic [3:0] exp);
        #1;
        push_exp(tag, {28'd0, exp});
        check_next(ctrl());
    endtask

    task automatic chk_cnt(input string tag, input int exp_stall, input int exp_flush);
        push_exp({tag, "_stall_cnt"}, 32'(exp_stall));
        check_next(32'(stall_cnt));
        push_exp({tag, "_flush_cnt"}, 32'(exp_flush));
        check_next(32'(flush_cnt));
    endtask

    // Advance one clock; inputs are changed 1 time unit after the edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; lw_stall = 1'b1; br_taken = 1'b1;
        forwardA = 2'b00; forwardB = 2'b00; forwardtoStore = 2'b00;
        rs1 = 32'h11; rs2 = 32'h11; exm = 32'h22; mwa = 32'h33; mwl = 32'h44; mwd = 32'h55;

        // Reset held two cycles with both hazard requests asserted
        tick(); tick();
        chk_ctrl("reset_ctrl", 4'b1100);
        chk_cnt("reset", 0, 0);
        push_exp("reset_store", 32'h0);
        check_next(store_data);
        RST = 1'b0; lw_stall = 1'b0; br_taken = 1'b0;
        chk_ctrl("run_after_reset", 4'b1100);

        // Load-use stall held for two cycles
        lw_stall = 1'b1;
        chk_ctrl("stall_cycle1", 4'b0001);
        tick();
        chk_ctrl("stall_cycle2_ignored", 4'b1100);
        tick();
        lw_stall = 1'b0;
        chk_ctrl("after_stall", 4'b1100);
        chk_cnt("stall", 1, 0);

        // Branch held for two cycles
        br_taken = 1'b1;
        chk_ctrl("flush_cycle1", 4'b1111);
        tick();
        chk_ctrl("flush_cycle2_ignored", 4'b1100);
        tick();
        br_taken = 1'b0;
        chk_ctrl("after_flush", 4'b1100);
        chk_cnt("flush", 1, 1);

        // Simultaneous: branch wins; in FLUSH a load-use request is ignored too
        lw_stall = 1'b1; br_taken = 1'b1;
        chk_ctrl("simul", 4'b1111);
        tick();
        br_taken = 1'b0;
        chk_ctrl("flush_ignores_lw", 4'b1100);
        tick();
        lw_stall = 1'b0;
        chk_cnt("simul", 1, 2);

        // Branch arriving in STALL takes effect and is counted
        lw_stall = 1'b1;
        chk_ctrl("stall_then_br_c1", 4'b0001);
        tick();
        lw_stall = 1'b0; br_taken = 1'b1;
        chk_ctrl("br_in_stall", 4'b1111);
        tick();
        br_taken = 1'b0;
        chk_ctrl("flush_after_stall", 4'b1100);
        tick();
        chk_cnt("br_in_stall", 2, 3);

        // Reset while in STALL
        lw_stall = 1'b1;
        tick();
        lw_stall = 1'b0; RST = 1'b1; br_taken = 1'b1;
        chk_ctrl("reset_in_stall_ctrl", 4'b1100);
        tick();
        RST = 1'b0; br_taken = 1'b0;
        chk_ctrl("run_after_mid_reset", 4'b1100);
        chk_cnt("mid_reset", 0, 0);

        // Operand forwarding, same-cycle
        for (int i = 0; i < 4; i++) begin
            logic [31:0] exp_v;
            forwardA = 2'(i);
            forwardB = 2'(3 - i);
            #1;
            exp_v = 32'h11 * 32'(i + 1);
            push_exp($sformatf("fwdA_sel%0d", i), exp_v);
            check_next(fwd_opA);
            exp_v = 32'h11 * 32'(4 - i);
            push_exp($sformatf("fwdB_sel%0d", 3 - i), exp_v);
            check_next(fwd_opB);
        end

        // Store-data register, one edge after the select
        forwardtoStore = 2'b01;
        push_exp("store_sel01", 32'h22);
        tick();
        check_next(store_data);
        forwardtoStore = 2'b10;
        push_exp("store_sel10", 32'h55);
        tick();
        check_next(store_data);
        forwardtoStore = 2'b11;
        push_exp("store_sel11", 32'h11);
        tick();
        check_next(store_data);
        rs2 = 32'h66; forwardtoStore = 2'b00;
        push_exp("store_sel00", 32'h66);
        tick();
        check_next(store_data);

        // Saturation: five separated stall pulses
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int p = 0; p < 5; p++) begin
            lw_stall = 1'b1;
            tick();
            lw_stall = 1'b0;
            tick();
        end
        push_exp("sat_stall_cnt", 32'd3);
        check_next(32'(s_stall_cnt));
        push_exp("sat_flush_cnt", 32'd0);
        check_next(32'(s_flush_cnt));
        chk_cnt("wide_after_pulses", 5, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
